// File: rtl/bitwise_pkg.sv
// bitwise_pkg
// Shared constants for the sequential bitwise logic unit: the 3-bit opcode
// encodings and the controller state encodings.
package bitwise_pkg;

   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/bitwise_slice.sv
// bitwise_slice
// Combinational CHUNK-wide bitwise operation unit.
// Ports:
//   a_s  in  CHUNK  operand A slice
//   b_s  in  CHUNK  operand B slice (ignored for NOT/PASS)
//   op   in  3      operation select
//   y_s  out CHUNK  result slice
module bitwise_slice
   import bitwise_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_s,
   input  logic [CHUNK-1:0] b_s,
   input  logic [2:0]       op,
   output logic [CHUNK-1:0] y_s
);

   always_comb begin
      y_s = a_s;
      case (op)
         OP_NOT:  y_s = ~a_s;
         OP_AND:  y_s = a_s & b_s;
         OP_OR:   y_s = a_s | b_s;
         OP_XOR:  y_s = a_s ^ b_s;
         OP_NAND: y_s = ~(a_s & b_s);
         OP_NOR:  y_s = ~(a_s | b_s);
         OP_XNOR: y_s = ~(a_s ^ b_s);
         default: y_s = a_s;
      endcase
   end

endmodule

// File: rtl/bitwise_logic_seq.sv
// bitwise_logic_seq
// Multi-operation bitwise unit that processes CHUNK bits per cycle through a
// single shared slice unit, with valid/ready handshakes on both sides.
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands/opcode present
//   in_ready   out  1      unit can accept (IDLE only)
//   op         in   3      operation select
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result present (DONE only)
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  computed word, stable while out_valid
//   zero       out  1      result == 0, meaningful with out_valid
//
// state | meaning
// IDLE  | waiting for an operation; in_ready high
// BUSY  | writing one CHUNK slice of the result per cycle
// DONE  | result and zero presented; waiting for out_ready
module bitwise_logic_seq
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("bitwise_logic_seq: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       state_q;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;

   logic [CHUNK-1:0] a_s;
   logic [CHUNK-1:0] b_s;
   logic [CHUNK-1:0] y_s;
   logic [WIDTH-1:0] result_nxt;
   logic             last_slice;
   int               base;

   assign base       = int'(idx_q) * CHUNK;
   assign a_s        = a_q[base +: CHUNK];
   assign b_s        = b_q[base +: CHUNK];
   assign last_slice = (idx_q == IDX_W'(N - 1));

   bitwise_slice #(.CHUNK(CHUNK)) u_slice (
      .a_s (a_s),
      .b_s (b_s),
      .op  (op_q),
      .y_s (y_s)
   );

   // Result with the current slice merged in; zero is taken from this on the
   // last edge so it reflects the fully assembled word.
   always_comb begin
      result_nxt               = result_q;
      result_nxt[base +: CHUNK] = y_s;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  idx_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               result_q <= result_nxt;
               if (last_slice) begin
                  zero_q  <= (result_nxt == '0);
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
module tb_bitwise_logic_seq;
   import bitwise_pkg::*;

   logic        clock;
   logic        reset;
   logic        iv   [4];
   logic        ir   [4];
   logic        ov   [4];
   logic        ordy [4];
   logic        zr   [4];
   logic [2:0]  opv  [4];
   logic [31:0] av   [4];
   logic [31:0] bv   [4];
   logic [31:0] rs   [3];
   logic [15:0] rs16;

   int n_cmp = 0;
   int n_err = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   bitwise_logic_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
      .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
      .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(rs[0]), .zero(zr[0]));
   bitwise_logic_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
      .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
      .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(rs[1]), .zero(zr[1]));
   bitwise_logic_seq #(.WIDTH(32), .CHUNK(1)) dut2 (
      .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .op(opv[2]),
      .a(av[2]), .b(bv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .result(rs[2]), .zero(zr[2]));
   bitwise_logic_seq #(.WIDTH(16), .CHUNK(4)) dut3 (
      .clock(clock), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .op(opv[3]),
      .a(av[3][15:0]), .b(bv[3][15:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .result(rs16), .zero(zr[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] get_res(input int k);
      if (k == 3) return {16'h0, rs16};
      return rs[k];
   endfunction

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input int w);
      logic [31:0] r;
      case (o)
         3'b000:  r = ~x;
         3'b001:  r = x & y;
         3'b010:  r = x | y;
         3'b011:  r = x ^ y;
         3'b100:  r = ~(x & y);
         3'b101:  r = ~(x | y);
         3'b110:  r = ~(x ^ y);
         default: r = x;
      endcase
      if (w < 32) r = r & ((32'h1 << w) - 32'h1);
      return r;
   endfunction

   // Full transaction on instance k; lat counts edges after acceptance until out_valid.
   task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int lat, output logic [31:0] r,
                         output logic z);
      int t;
      t = 0;
      while (!ir[k] && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk("in_ready_wait", {31'h0, ir[k]}, 32'h1);
      @(negedge clock);
      iv[k] = 1'b1; opv[k] = o; av[k] = x; bv[k] = y;
      @(posedge clock);
      #1 iv[k] = 1'b0;
      lat = 0;
      while (!ov[k] && lat < 100) begin
         @(posedge clock);
         #1 lat++;
      end
      r = get_res(k);
      z = zr[k];
      ordy[k] = 1'b1;
      @(posedge clock);
      #1 ordy[k] = 1'b0;
   endtask

   int          lat;
   logic [31:0] r, x, y, e;
   logic        z;
   int          seen;
   int          nn [4] = '{4, 1, 32, 4};
   int          ww [4] = '{32, 32, 32, 16};

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; opv[k] = 3'b0; av[k] = '0; bv[k] = '0;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      chk("rst_in_ready", {31'h0, ir[0]}, 32'h1);
      chk("rst_out_valid", {31'h0, ov[0]}, 32'h0);
      chk("rst_result", rs[0], 32'h0);
      chk("rst_zero", {31'h0, zr[0]}, 32'h0);

      run_op(0, OP_NOT, 32'h0000_FFFF, 32'h1234_5678, lat, r, z);
      chk("not_latency", lat, 4);
      chk("not_result", r, 32'hFFFF_0000);
      chk("not_zero", {31'h0, z}, 32'h0);

      run_op(0, OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, r, z);
      chk("xor_result", r, 32'h0);
      chk("xor_zero", {31'h0, z}, 32'h1);

      run_op(0, OP_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, r, z);
      chk("nand_result", r, 32'h0FFF_0FFF);
      chk("nand_zero", {31'h0, z}, 32'h0);

      // Inputs churn during BUSY with in_valid held high.
      @(negedge clock);
      iv[0] = 1'b1; opv[0] = OP_AND; av[0] = 32'h1234_5678; bv[0] = 32'h0F0F_0F0F;
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("busy_in_ready", {31'h0, ir[0]}, 32'h0);
         opv[0] = 3'($urandom_range(7)); av[0] = $urandom; bv[0] = $urandom;
         @(posedge clock);
         #1;
      end
      chk("busy_in_ready_last", {31'h0, ir[0]}, 32'h0);
      @(posedge clock);
      #1;
      chk("flight_valid", {31'h0, ov[0]}, 32'h1);
      chk("flight_result", rs[0], 32'h0204_0608);
      for (int i = 0; i < 10; i++) begin
         opv[0] = 3'($urandom_range(7)); av[0] = $urandom; bv[0] = $urandom;
         @(posedge clock);
         #1;
         chk("stall_valid", {31'h0, ov[0]}, 32'h1);
         chk("stall_in_ready", {31'h0, ir[0]}, 32'h0);
         chk("stall_result", rs[0], 32'h0204_0608);
         chk("stall_zero", {31'h0, zr[0]}, 32'h0);
      end
      ordy[0] = 1'b1; opv[0] = OP_XNOR; av[0] = 32'hF0F0_F0F0; bv[0] = 32'h0F0F_0F0F;
      @(posedge clock);
      #1;
      chk("bubble_out_valid", {31'h0, ov[0]}, 32'h0);
      chk("bubble_in_ready", {31'h0, ir[0]}, 32'h1);
      ordy[0] = 1'b0;
      @(posedge clock);
      #1;
      chk("post_bubble_accept", {31'h0, ir[0]}, 32'h0);
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 100) begin
         @(posedge clock);
         #1 lat++;
      end
      chk("xnor_latency", lat, 4);
      chk("xnor_result", rs[0], 32'h0);
      chk("xnor_zero", {31'h0, zr[0]}, 32'h1);
      ordy[0] = 1'b1;
      @(posedge clock);
      #1 ordy[0] = 1'b0;

      // Reset while slice 2 is pending.
      @(negedge clock);
      iv[0] = 1'b1; opv[0] = OP_OR; av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0;
      @(posedge clock);
      #1 iv[0] = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_in_ready", {31'h0, ir[0]}, 32'h1);
      chk("midrst_out_valid", {31'h0, ov[0]}, 32'h0);
      chk("midrst_result", rs[0], 32'h0);
      chk("midrst_zero", {31'h0, zr[0]}, 32'h0);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clock);
         if (ov[0]) seen++;
      end
      chk("midrst_no_valid", seen, 0);
      run_op(0, OP_OR, 32'h0000_0001, 32'h8000_0000, lat, r, z);
      chk("or_latency", lat, 4);
      chk("or_result", r, 32'h8000_0001);

      // All opcodes against the model on every configuration.
      for (int k = 0; k < 4; k++) begin
         for (int o = 0; o < 8; o++) begin
            x = $urandom; y = $urandom;
            if (ww[k] < 32) begin
               x = x & 32'h0000_FFFF;
               y = y & 32'h0000_FFFF;
            end
            e = model(3'(o), x, y, ww[k]);
            run_op(k, 3'(o), x, y, lat, r, z);
            chk("sweep_latency", lat, nn[k]);
            chk("sweep_result", r, e);
            chk("sweep_zero", {31'h0, z}, {31'h0, (e == 32'h0)});
         end
         run_op(k, OP_AND, 32'h0000_A5A5, 32'h0000_5A5A, lat, r, z);
         chk("sweep_and_zero", {31'h0, z}, 32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
